// File: rtl/bcd_scan_display.sv
// Eight-digit multiplexed seven-segment driver: two 4-tube buses scanned in parallel,
// frame-coherent snapshot of time_data, optional digit blink (BCD_SCAN_DISPLAY_BLINK_EN).
module bcd_scan_display #(
   parameter int SCAN_DIV  = 100_000,
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        display_on,
   input  logic [31:0] time_data,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  blink_mask,
   output logic [7:0]  digit1,
   output logic [7:0]  digit2,
   output logic [7:0]  tube_sel
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [SW-1:0] step_cnt;
   logic [1:0]    idx;
   logic [31:0]   shadow;
   logic [7:0]    dp_snap;
   logic [7:0]    blink_snap;
   logic          step_end;
   logic          blink_phase;
   logic [2:0]    lo_tube;
   logic [2:0]    hi_tube;
   logic [7:0]    seg_lo;
   logic [7:0]    seg_hi;
   logic [7:0]    sel_next;

   // Segment order a,b,c,d,e,f,g,dp; codes E and F are blank and dash.
   function automatic logic [7:0] glyph(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'b1111_1100;
         4'h1:    seg = 8'b0110_0000;
         4'h2:    seg = 8'b1101_1010;
         4'h3:    seg = 8'b1111_0010;
         4'h4:    seg = 8'b0110_0110;
         4'h5:    seg = 8'b1011_0110;
         4'h6:    seg = 8'b1011_1110;
         4'h7:    seg = 8'b1110_0000;
         4'h8:    seg = 8'b1111_1110;
         4'h9:    seg = 8'b1111_0110;
         4'hA:    seg = 8'b1110_1110;
         4'hB:    seg = 8'b0011_1110;
         4'hC:    seg = 8'b1001_1100;
         4'hD:    seg = 8'b0111_1010;
         4'hE:    seg = 8'b0000_0000;
         4'hF:    seg = 8'b0000_0010;
         default: seg = 8'b0000_0000;
      endcase
      return seg;
   endfunction

   assign step_end = (step_cnt == SW'(SCAN_DIV - 1));

   // Scan step counter, tube index and the frame snapshot taken on the 3->0 wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_cnt   <= '0;
         idx        <= 2'd0;
         shadow     <= 32'hEEEE_EEEE;
         dp_snap    <= 8'h00;
         blink_snap <= 8'h00;
      end else if (step_end) begin
         step_cnt <= '0;
         idx      <= idx + 2'd1;
         if (idx == 2'd3) begin
            shadow     <= time_data;
            dp_snap    <= dp_mask;
            blink_snap <= blink_mask;
         end
      end else begin
         step_cnt <= step_cnt + SW'(1);
      end
   end

`ifdef BCD_SCAN_DISPLAY_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BW-1:0] blink_cnt;

   // Free-running blink half-period counter, independent of the scan.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end
`else
   // Without blink support no tube is ever gated; the snapshot mask folds away.
   assign blink_phase = 1'b0;
`endif

   assign lo_tube = {1'b0, idx};
   assign hi_tube = {1'b1, idx};

   // Next bus values for the current scan step; a blinking tube also drops its dp.
   always_comb begin
      sel_next = (8'h01 << idx) | (8'h10 << idx);
      if (blink_phase && blink_snap[lo_tube]) begin
         seg_lo = 8'h00;
      end else begin
         seg_lo = glyph(shadow[{lo_tube, 2'b00} +: 4]) | {7'b000_0000, dp_snap[lo_tube]};
      end
      if (blink_phase && blink_snap[hi_tube]) begin
         seg_hi = 8'h00;
      end else begin
         seg_hi = glyph(shadow[{hi_tube, 2'b00} +: 4]) | {7'b000_0000, dp_snap[hi_tube]};
      end
   end

   // Registered drivers; display_on only masks the outputs, counters keep running.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tube_sel <= 8'h00;
         digit1   <= 8'h00;
         digit2   <= 8'h00;
      end else if (!display_on) begin
         tube_sel <= 8'h00;
         digit1   <= 8'h00;
         digit2   <= 8'h00;
      end else begin
         tube_sel <= sel_next;
         digit1   <= seg_hi;
         digit2   <= seg_lo;
      end
   end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed 8-digit seven-segment driver: the display end of the 32-bit `time_data` interface that the control blocks (power/gesture-timeout control, clock, alarm) fill with BCD nibbles. It snapshots `time_data` once per refresh frame and decodes the nibbles to segment patterns. It then scans the two 4-digit segment buses in parallel and can blink selected digits to mark the field being adjusted.

## Interface
Parameters:
- `SCAN_DIV`, 100_000: clk cycles per scan step (1 kHz step at 100 MHz; 250 Hz full frame).
- `BLINK_DIV`, 50_000_000: clk cycles per blink half-period (1 Hz blink at 100 MHz).

Ports (reset `rst`, asynchronous, active-low; clock `clk`):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-low reset.
- `display_on` in 1: 1 = display active; 0 = all tubes dark (driven by machine_state).
- `time_data` in 32: nibble n (bits 4n+3:4n) is the glyph code for tube n; tube 7 is leftmost.
- `dp_mask` in 8: bit n lights the decimal point of tube n.
- `blink_mask` in 8: bit n makes tube n blink.
- `digit1` out 8: segment bus for tubes 7..4, active-high, bit7..bit0 = a,b,c,d,e,f,g,dp.
- `digit2` out 8: segment bus for tubes 3..0, same encoding.
- `tube_sel` out 8: one-hot-per-bus tube enable, active-high; bit n = tube n.

## Operation
- Glyph decode: 0x0–0x9 are digits; 0xA = A, 0xB = b, 0xC = C, 0xD = d; 0xE = blank (all segments 0); 0xF = dash (segment g only, 8'b0000_0010). Digit patterns are standard: 0 = 8'b1111_1100, 1 = 8'b0110_0000, 8 = 8'b1111_1110.
- Scan index `idx` is 2 bits, 0..3. At step `idx` = k, `tube_sel` = (1<<k) | (1<<(k+4)). `digit2` shows nibble k and `digit1` shows nibble k+4.
- `dp` bit = `dp_mask` bit of the displayed tube, ORed after decode. Blank and dash glyphs still honour dp.
- Snapshot: an internal 32-bit `shadow` captures `time_data` and both masks when `idx` wraps from 3 to 0. Mid-frame changes never tear a frame.
- Blink: `blink_phase` toggles every BLINK_DIV cycles. While `blink_phase` = 1, a tube whose snapshot `blink_mask` bit is set drives its bus to 8'h00, including dp. Its `tube_sel` bit stays asserted.
- `display_on` = 0: `tube_sel`, `digit1` and `digit2` are forced to 0. Scan, blink and snapshot counters keep running.

## Timing
- Reset values: `tube_sel` = 0, `digit1` = `digit2` = 0, `idx` = 0, step counter = 0, blink counter = 0, `blink_phase` = 0, `shadow` = 32'hEEEE_EEEE (blank), mask snapshots = 0.
- Step counter counts 0..SCAN_DIV-1. On the terminal count it returns to 0 and `idx` increments modulo 4. The snapshot is taken in the same cycle as the 3→0 wrap.
- Outputs are registered with 1-cycle latency from `idx`, `shadow`, `blink_phase` and `display_on`. The first frame after reset shows all blank until the first wrap, which occurs at 4·SCAN_DIV cycles.
- The blink counter counts 0..BLINK_DIV-1 independently of the scan counter. `blink_phase` flips in the terminal cycle.
- A terminal-count collision between scan and blink takes both effects in the same cycle; the new phase applies to the output in the next cycle.
- Reset asserted mid-frame returns every output to its reset value immediately (asynchronous). Scanning resumes from `idx` 0 on the first clk after release.
- Parameter values of 1 must work: the step counter stays 0 and `idx` advances every cycle.

## Configuration
- `BCD_SCAN_DISPLAY_BLINK_EN` defined: the blink counter, `blink_phase` and `blink_mask` gating are present as described.
- Not defined: the blink logic is removed, the `blink_mask` port remains but is ignored, and tubes are never blanked by blink.

## Test plan
- SCAN_DIV=4, reset release, `time_data`=32'h1234_5678, `display_on`=1: blank for 16 cycles, then `tube_sel` 8'h11/`digit2`=glyph 8/`digit1`=glyph 4, then 8'h22 (7/3), 8'h44 (6/2), 8'h88 (5/1), each held 4 cycles.
- `time_data`=32'h00FE_FF59 with `dp_mask`=8'h04: tube 2 shows the dash plus dp (8'b0000_0011), tubes 3 and 5 show dash, tube 4 is blank, tubes 6 and 7 show 0.
- Change `time_data` while `idx`=2: the outputs keep the old values until the next 3→0 wrap, then all four steps show the new values.
- With BLINK_EN, BLINK_DIV=8, `blink_mask`=8'h03: tubes 0 and 1 read 8'h00 in alternate 8-cycle windows and other tubes are unaffected. Without the macro, tubes 0 and 1 never blank.
- `display_on` 1→0→1 mid-frame: the outputs go to 0 one cycle after the fall. Scan `idx` continues, so the display resumes at the advanced `idx` one cycle after the rise.
- Assert `rst` mid-step: all outputs read 0 in the same cycle, and after release the sequence restarts at `idx` 0 with a blank shadow.
